mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between EXE and WB of the 5-stage RV core.
//  - Accepts the EXE result bus and waits for load data from the data SRAM.
//    The request was already issued in EXE; the response may take 0..N cycles.
//  - Selects and sign-extends the load byte, then forwards the writeback bus to WB.
//  - Drives bypass and load-stall information back to ID.
// PARAMETERS
//  EXE_TO_MEM_BUS_WD  72   {dst_load,dst_writeback,alu_result[31:0],rd[4:0],pc[31:0],ebreak}
//  MEM_TO_WB_BUS_WD   71   {dst_writeback,final_result[31:0],rd[4:0],pc[31:0],ebreak}
//  RDATA_TIMEOUT      255  max cycles spent in WAIT before the load is forcibly completed
// PORTS
//  clk                    in   1    single clock, rising edge
//  reset                  in   1    synchronous, active-high
//  wb_allowin             in   1    WB can accept an instruction this cycle
//  mem_allowin            out  1    this stage can accept from EXE this cycle
//  exe_to_mem_valid       in   1    EXE presents a valid instruction
//  exe_to_mem_bus         in   72   see EXE_TO_MEM_BUS_WD
//  data_sram_rdata        in   32   load response data (word-aligned)
//  data_sram_rvalid       in   1    load response valid, one-cycle pulse
//  mem_to_wb_valid        out  1    valid instruction toward WB
//  mem_to_wb_bus          out  71   see MEM_TO_WB_BUS_WD
//  mem_to_id_bypass       out  32   final_result of the held instruction
//  mem_to_id_rdbypass     out  5    rd of the held instruction
//  mem_to_id_rfwenbypass  out  1    mem_valid && dst_writeback
//  mem_to_id_loadbypass   out  1    mem_valid && dst_load && !ready_go (ID must stall)
//  mem_err                out  1    sticky: a load hit RDATA_TIMEOUT
// BEHAVIOUR
//  Handshake
//  - mem_allowin = !mem_valid || (ready_go && wb_allowin).
//  - On exe_to_mem_valid && mem_allowin, bus_r <= exe_to_mem_bus.
//  - When mem_allowin is high, mem_valid <= exe_to_mem_valid at the edge.
//  - mem_to_wb_valid = mem_valid && ready_go.
//  FSM (state resets to IDLE)
//  - IDLE: no load pending. Entering a load moves to WAIT; anything else stays in IDLE.
//  - WAIT: load with no data yet.
//    - rvalid && !wb_allowin: capture rdata into rbuf, go to DONE.
//    - rvalid && wb_allowin: pass rdata straight through. Next state is WAIT if a new
//      load enters, otherwise IDLE.
//  - DONE: data held in rbuf. Leaves when wb_allowin; next state as for WAIT pass-through.
//  - ready_go = !dst_load | DONE | (WAIT & rvalid) | (WAIT & cnt==RDATA_TIMEOUT).
//    Combinational, zero added latency when rvalid arrives in the first WAIT cycle.
//  Timeout counter cnt (8b)
//  - Clears on WAIT entry and increments each WAIT cycle without rvalid.
//  - At cnt==RDATA_TIMEOUT: the load completes with data 32'h0 and mem_err <= 1.
//    mem_err stays set until reset.
//  Result path
//  - Non-load: final_result = alu_result.
//  - Load: byte = rdata >> (8*alu_result[1:0]); final_result = {{24{byte[7]}},byte[7:0]}.
//    This is the LB behaviour matching SB-only stores.
//  - rdata source: rbuf in DONE, data_sram_rdata otherwise.
//  Edge cases
//  - rvalid outside WAIT (IDLE, DONE, mem_valid=0) is ignored; no capture, no state change.
//  - Reset mid-WAIT or mid-DONE: the pending load is dropped and state goes to IDLE.
//    A late rvalid after reset is ignored.
//  Reset values
//  - mem_valid=0, state=IDLE, cnt=0, mem_err=0, rbuf=0.
//  - Hence mem_to_wb_valid, mem_to_id_rfwenbypass and mem_to_id_loadbypass are all 0.
//  - mem_allowin=1.
//  - Bus outputs reflect bus_r, reset to 0.
// TESTING
//  - ALU op, rd=5, alu_result=0x1234, wb_allowin=1 -> next cycle mem_to_wb_valid=1,
//    final_result=0x1234, rfwenbypass=1, loadbypass=0.
//  - Load, addr[1:0]=2, rdata=0x00800000, rvalid in the first cycle ->
//    final_result=0xFFFFFF80 the same cycle, no stall.
//  - Load, rvalid 3 cycles late -> loadbypass=1 and mem_allowin=0 for 3 cycles,
//    then one WB transfer with the sign-extended byte.
//  - Load with rvalid while wb_allowin=0 for 2 cycles -> state DONE, rbuf holds the data,
//    a later rvalid pulse is ignored, the correct byte goes out when wb_allowin=1.
//  - Load with no rvalid -> after RDATA_TIMEOUT cycles the load completes with result 0
//    and mem_err=1 until reset.
//  - Back-to-back loads with wb_allowin=1 and rvalid each cycle -> one WB transfer per
//    cycle, WAIT->WAIT; reset asserted mid-WAIT -> mem_to_wb_valid=0, state IDLE.

Source files
------------

// File: rtl/mem_stage_if.sv
// Signal bundle around the MEM stage: EXE input bus, data SRAM response,
// WB output bus and the bypass/stall feedback toward ID.
interface mem_stage_if #(
    parameter int EXE_TO_MEM_BUS_WD = 72,
    parameter int MEM_TO_WB_BUS_WD  = 71
);
    logic                         wb_allowin;
    logic                         mem_allowin;
    logic                         exe_to_mem_valid;
    logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus;
    logic [31:0]                  data_sram_rdata;
    logic                         data_sram_rvalid;
    logic                         mem_to_wb_valid;
    logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus;
    logic [31:0]                  mem_to_id_bypass;
    logic [4:0]                   mem_to_id_rdbypass;
    logic                         mem_to_id_rfwenbypass;
    logic                         mem_to_id_loadbypass;
    logic                         mem_err;

    modport slave (
        input  wb_allowin, exe_to_mem_valid, exe_to_mem_bus,
               data_sram_rdata, data_sram_rvalid,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               mem_to_id_bypass, mem_to_id_rdbypass,
               mem_to_id_rfwenbypass, mem_to_id_loadbypass, mem_err
    );

    modport master (
        output wb_allowin, exe_to_mem_valid, exe_to_mem_bus,
               data_sram_rdata, data_sram_rvalid,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               mem_to_id_bypass, mem_to_id_rdbypass,
               mem_to_id_rfwenbypass, mem_to_id_loadbypass, mem_err
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EXE result, waits for load data (with timeout),
// selects/sign-extends the load byte and forwards the writeback bus to WB.
module mem_stage #(
    parameter int EXE_TO_MEM_BUS_WD = 72,
    parameter int MEM_TO_WB_BUS_WD  = 71,
    parameter int RDATA_TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave io_if
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] TIMEOUT = 8'(RDATA_TIMEOUT);

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         r_mem_valid;
    logic [EXE_TO_MEM_BUS_WD-1:0] r_bus;
    logic [7:0]                   r_cnt;
    logic                         r_err;
    logic [31:0]                  r_rbuf;

    logic                         w_dst_load;
    logic                         w_dst_wb;
    logic [31:0]                  w_alu;
    logic [4:0]                   w_rd;
    logic                         w_rvalid;
    logic                         w_timeout;
    logic                         w_ready_go;
    logic [31:0]                  w_rdata;
    logic                         w_mem_allowin;
    logic                         w_load_in;
    logic [7:0]                   w_lane [4];
    logic [7:0]                   w_byte;
    logic [31:0]                  w_final;

    assign w_dst_load = r_bus[71];
    assign w_dst_wb   = r_bus[70];
    assign w_alu      = r_bus[69:38];
    assign w_rd       = r_bus[37:33];
    assign w_rvalid   = io_if.data_sram_rvalid;
    // Timeout only forces completion when the real response did not arrive this cycle.
    assign w_timeout  = (r_state == S_WAIT) && !w_rvalid && (r_cnt == TIMEOUT);

    assign w_mem_allowin = !r_mem_valid || (w_ready_go && io_if.wb_allowin);
    assign w_load_in     = io_if.exe_to_mem_valid && w_mem_allowin && io_if.exe_to_mem_bus[71];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load_in) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_rvalid && !io_if.wb_allowin) begin
                    w_state_next = S_DONE;
                end else if ((w_rvalid || r_cnt == TIMEOUT) && io_if.wb_allowin) begin
                    w_state_next = w_load_in ? S_WAIT : S_IDLE;
                end
            end
            S_DONE: begin
                if (io_if.wb_allowin) w_state_next = w_load_in ? S_WAIT : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: completion and load-data source
    always_comb begin
        w_ready_go = !w_dst_load;
        w_rdata    = io_if.data_sram_rdata;
        case (r_state)
            S_WAIT: begin
                if (w_rvalid || r_cnt == TIMEOUT) w_ready_go = 1'b1;
                if (w_timeout) w_rdata = 32'h0;
            end
            S_DONE: begin
                w_ready_go = 1'b1;
                w_rdata    = r_rbuf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_valid <= 1'b0;
            r_bus       <= '0;
            r_cnt       <= 8'd0;
            r_err       <= 1'b0;
            r_rbuf      <= 32'h0;
        end else begin
            if (w_mem_allowin) r_mem_valid <= io_if.exe_to_mem_valid;
            if (io_if.exe_to_mem_valid && w_mem_allowin) r_bus <= io_if.exe_to_mem_bus;
            if (w_load_in) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_WAIT && !w_rvalid && r_cnt != TIMEOUT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_timeout) r_err <= 1'b1;
            if (r_state == S_WAIT && w_rvalid && !io_if.wb_allowin) r_rbuf <= io_if.data_sram_rdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = w_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte  = w_lane[w_alu[1:0]];
    assign w_final = w_dst_load ? {{24{w_byte[7]}}, w_byte} : w_alu;

    assign io_if.mem_allowin           = w_mem_allowin;
    assign io_if.mem_to_wb_valid       = r_mem_valid && w_ready_go;
    assign io_if.mem_to_wb_bus         = {w_dst_wb, w_final, w_rd, r_bus[32:0]};
    assign io_if.mem_to_id_bypass      = w_final;
    assign io_if.mem_to_id_rdbypass    = w_rd;
    assign io_if.mem_to_id_rfwenbypass = r_mem_valid && w_dst_wb;
    assign io_if.mem_to_id_loadbypass  = r_mem_valid && w_dst_load && !w_ready_go;
    assign io_if.mem_err               = r_err;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass, fast/late loads, DONE buffering,
// timeout with sticky error, back-to-back loads and reset mid-WAIT.
module tb_mem_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_stage_if #(.EXE_TO_MEM_BUS_WD(72), .MEM_TO_WB_BUS_WD(71)) vif ();

    mem_stage #(.EXE_TO_MEM_BUS_WD(72), .MEM_TO_WB_BUS_WD(71), .RDATA_TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .io_if (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] fres;
    logic [4:0]  frd;
    logic [31:0] fpc;
    assign fres = vif.mem_to_wb_bus[69:38];
    assign frd  = vif.mem_to_wb_bus[37:33];
    assign fpc  = vif.mem_to_wb_bus[32:1];

    function automatic logic [71:0] mk(input logic ld, input logic wb, input logic [31:0] alu,
                                       input logic [4:0] rd, input logic [31:0] pc);
        return {ld, wb, alu, rd, pc, 1'b0};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vif.exe_to_mem_valid = 1'b0;
        vif.exe_to_mem_bus   = '0;
        vif.data_sram_rvalid = 1'b0;
        vif.data_sram_rdata  = 32'h0;
        vif.wb_allowin       = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        checks++; if (vif.mem_to_wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%0b exp=0", vif.mem_to_wb_valid); end
        checks++; if (vif.mem_allowin !== 1'b1) begin failures++; $display("FAIL rst_allowin got=%0b exp=1", vif.mem_allowin); end
        checks++; if (vif.mem_to_id_rfwenbypass !== 1'b0 || vif.mem_to_id_loadbypass !== 1'b0) begin failures++; $display("FAIL rst_bypass got=%0b%0b exp=00", vif.mem_to_id_rfwenbypass, vif.mem_to_id_loadbypass); end
        checks++; if (vif.mem_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", vif.mem_err); end
        checks++; if (vif.mem_to_wb_bus !== 71'h0) begin failures++; $display("FAIL rst_bus got=%0h exp=0", vif.mem_to_wb_bus); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_alu();
        vif.exe_to_mem_valid = 1'b1;
        vif.exe_to_mem_bus   = mk(1'b0, 1'b1, 32'h1234, 5'd5, 32'h100);
        step();
        vif.exe_to_mem_valid = 1'b0;
        checks++; if (vif.mem_to_wb_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%0b exp=1", vif.mem_to_wb_valid); end
        checks++; if (fres !== 32'h1234 || frd !== 5'd5 || fpc !== 32'h100) begin failures++; $display("FAIL alu_bus res=%0h rd=%0d pc=%0h exp 1234/5/100", fres, frd, fpc); end
        checks++; if (vif.mem_to_id_rfwenbypass !== 1'b1 || vif.mem_to_id_loadbypass !== 1'b0) begin failures++; $display("FAIL alu_bypass got=%0b%0b exp=10", vif.mem_to_id_rfwenbypass, vif.mem_to_id_loadbypass); end
        checks++; if (vif.mem_to_id_bypass !== 32'h1234 || vif.mem_to_id_rdbypass !== 5'd5) begin failures++; $display("FAIL alu_idbyp got=%0h/%0d exp=1234/5", vif.mem_to_id_bypass, vif.mem_to_id_rdbypass); end
        step();
        checks++; if (vif.mem_to_wb_valid !== 1'b0) begin failures++; $display("FAIL alu_drain got=%0b exp=0", vif.mem_to_wb_valid); end
        $display("test_alu done");
    endtask

    task automatic test_load_fast();
        vif.exe_to_mem_valid = 1'b1;
        vif.exe_to_mem_bus   = mk(1'b1, 1'b1, 32'h2002, 5'd7, 32'h104);
        step();
        vif.exe_to_mem_valid = 1'b0;
        vif.data_sram_rvalid = 1'b1;
        vif.data_sram_rdata  = 32'h0080_0000;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || fres !== 32'hFFFF_FF80) begin failures++; $display("FAIL fast_load valid=%0b res=%0h exp 1/ffffff80", vif.mem_to_wb_valid, fres); end
        checks++; if (vif.mem_to_id_loadbypass !== 1'b0 || vif.mem_allowin !== 1'b1) begin failures++; $display("FAIL fast_stall lb=%0b allow=%0b exp 0/1", vif.mem_to_id_loadbypass, vif.mem_allowin); end
        step();
        vif.data_sram_rvalid = 1'b0;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b0) begin failures++; $display("FAIL fast_drain got=%0b exp=0", vif.mem_to_wb_valid); end
        $display("test_load_fast done");
    endtask

    task automatic test_load_late();
        int stall_cycles;
        stall_cycles = 0;
        vif.exe_to_mem_valid = 1'b1;
        vif.exe_to_mem_bus   = mk(1'b1, 1'b1, 32'h3001, 5'd8, 32'h108);
        step();
        vif.exe_to_mem_valid = 1'b0;
        vif.data_sram_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (vif.mem_to_id_loadbypass === 1'b1 && vif.mem_allowin === 1'b0 && vif.mem_to_wb_valid === 1'b0)
                stall_cycles++;
            step();
        end
        checks++; if (stall_cycles != 3) begin failures++; $display("FAIL late_stall cycles=%0d exp=3", stall_cycles); end
        vif.data_sram_rvalid = 1'b1;
        vif.data_sram_rdata  = 32'h0000_7F00;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || fres !== 32'h0000_007F || frd !== 5'd8) begin failures++; $display("FAIL late_data valid=%0b res=%0h rd=%0d exp 1/7f/8", vif.mem_to_wb_valid, fres, frd); end
        step();
        vif.data_sram_rvalid = 1'b0;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b0) begin failures++; $display("FAIL late_drain got=%0b exp=0", vif.mem_to_wb_valid); end
        $display("test_load_late done");
    endtask

    task automatic test_done_buffer();
        vif.wb_allowin       = 1'b0;
        vif.exe_to_mem_valid = 1'b1;
        vif.exe_to_mem_bus   = mk(1'b1, 1'b1, 32'h4003, 5'd9, 32'h10C);
        step();
        vif.exe_to_mem_valid = 1'b0;
        vif.data_sram_rvalid = 1'b1;
        vif.data_sram_rdata  = 32'hA500_0000;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || vif.mem_allowin !== 1'b0) begin failures++; $display("FAIL done_hold valid=%0b allow=%0b exp 1/0", vif.mem_to_wb_valid, vif.mem_allowin); end
        step();
        vif.data_sram_rdata = 32'h1111_1111;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || fres !== 32'hFFFF_FFA5) begin failures++; $display("FAIL done_ignore valid=%0b res=%0h exp 1/ffffffa5", vif.mem_to_wb_valid, fres); end
        step();
        vif.data_sram_rvalid = 1'b0;
        vif.data_sram_rdata  = 32'h0;
        vif.wb_allowin       = 1'b1;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || fres !== 32'hFFFF_FFA5 || vif.mem_allowin !== 1'b1) begin failures++; $display("FAIL done_release valid=%0b res=%0h allow=%0b exp 1/ffffffa5/1", vif.mem_to_wb_valid, fres, vif.mem_allowin); end
        step();
        checks++; if (vif.mem_to_wb_valid !== 1'b0) begin failures++; $display("FAIL done_drain got=%0b exp=0", vif.mem_to_wb_valid); end
        $display("test_done_buffer done");
    endtask

    task automatic test_timeout();
        int stall_cycles;
        stall_cycles = 0;
        vif.exe_to_mem_valid = 1'b1;
        vif.exe_to_mem_bus   = mk(1'b1, 1'b1, 32'h5000, 5'd10, 32'h110);
        step();
        vif.exe_to_mem_valid = 1'b0;
        vif.data_sram_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 255; i++) begin
            if (vif.mem_to_id_loadbypass === 1'b1 && vif.mem_to_wb_valid === 1'b0) stall_cycles++;
            step();
        end
        checks++; if (stall_cycles != 255) begin failures++; $display("FAIL to_stall cycles=%0d exp=255", stall_cycles); end
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || fres !== 32'h0 || vif.mem_err !== 1'b0) begin failures++; $display("FAIL to_complete valid=%0b res=%0h err=%0b exp 1/0/0", vif.mem_to_wb_valid, fres, vif.mem_err); end
        step();
        checks++; if (vif.mem_err !== 1'b1 || vif.mem_to_wb_valid !== 1'b0) begin failures++; $display("FAIL to_err err=%0b valid=%0b exp 1/0", vif.mem_err, vif.mem_to_wb_valid); end
        step();
        step();
        checks++; if (vif.mem_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0b exp=1", vif.mem_err); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (vif.mem_err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%0b exp=0", vif.mem_err); end
        $display("test_timeout done");
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        vif.exe_to_mem_valid = 1'b1;
        vif.exe_to_mem_bus   = mk(1'b1, 1'b1, 32'h6000, 5'd1, 32'h200);
        step();
        vif.exe_to_mem_bus   = mk(1'b1, 1'b1, 32'h6001, 5'd2, 32'h204);
        vif.data_sram_rvalid = 1'b1;
        vif.data_sram_rdata  = 32'h0000_00F0;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || fres !== 32'hFFFF_FFF0 || frd !== 5'd1 || vif.mem_allowin !== 1'b1) begin failures++; $display("FAIL b2b_first valid=%0b res=%0h rd=%0d allow=%0b", vif.mem_to_wb_valid, fres, frd, vif.mem_allowin); end
        step();
        vif.exe_to_mem_bus   = mk(1'b1, 1'b1, 32'h6002, 5'd3, 32'h208);
        vif.data_sram_rdata  = 32'h0000_3400;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || fres !== 32'h0000_0034 || frd !== 5'd2) begin failures++; $display("FAIL b2b_second valid=%0b res=%0h rd=%0d exp 1/34/2", vif.mem_to_wb_valid, fres, frd); end
        step();
        vif.exe_to_mem_valid = 1'b0;
        vif.data_sram_rvalid = 1'b0;
        #1;
        checks++; if (vif.mem_to_id_loadbypass !== 1'b1 || vif.mem_to_wb_valid !== 1'b0 || frd !== 5'd3) begin failures++; $display("FAIL b2b_third_wait lb=%0b valid=%0b rd=%0d exp 1/0/3", vif.mem_to_id_loadbypass, vif.mem_to_wb_valid, frd); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (vif.mem_to_wb_valid !== 1'b0 || vif.mem_to_id_loadbypass !== 1'b0 || vif.mem_allowin !== 1'b1) begin failures++; $display("FAIL b2b_reset valid=%0b lb=%0b allow=%0b exp 0/0/1", vif.mem_to_wb_valid, vif.mem_to_id_loadbypass, vif.mem_allowin); end
        vif.data_sram_rvalid = 1'b1;
        vif.data_sram_rdata  = 32'h0000_0080;
        step();
        vif.data_sram_rvalid = 1'b0;
        #1;
        checks++; if (vif.mem_to_wb_valid !== 1'b0 || vif.mem_allowin !== 1'b1) begin failures++; $display("FAIL b2b_late_rvalid valid=%0b allow=%0b exp 0/1", vif.mem_to_wb_valid, vif.mem_allowin); end
        // A fresh ALU op after the ignored pulse must still pass straight through.
        vif.exe_to_mem_valid = 1'b1;
        vif.exe_to_mem_bus   = mk(1'b0, 1'b1, 32'h0000_0777, 5'd4, 32'h20C);
        step();
        vif.exe_to_mem_valid = 1'b0;
        checks++; if (vif.mem_to_wb_valid !== 1'b1 || fres !== 32'h0000_0777) begin failures++; $display("FAIL b2b_after_reset valid=%0b res=%0h exp 1/777", vif.mem_to_wb_valid, fres); end
        $display("test_back_to_back done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_alu();
        test_load_fast();
        test_load_late();
        test_done_buffer();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
